// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sclk_gen
//  Description : SPI serial-clock and chip-select generator. Produces SCLK
//                with a programmable half-period, leading/trailing edge
//                strobes for a downstream shifter, and busy/done status.
//                Optional chip-select guard phases (SETUP before the first
//                SCLK edge, HOLD after the last) are enabled by defining
//                SPI_SCLK_GEN_CS_GUARD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_sclk_gen #(
  parameter int DIV_WIDTH = 8,
  parameter int BIT_WIDTH = 6
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_start,
  input  logic [DIV_WIDTH-1:0] i_half_period,
  input  logic [BIT_WIDTH-1:0] i_num_bits,
  input  logic                 i_cpol,
  output logic                 o_sclk,
  output logic                 o_cs_n,
  output logic                 o_lead_edge,
  output logic                 o_sclk_enable,
  output logic                 o_busy,
  output logic                 o_done
);

`ifdef SPI_SCLK_GEN_CS_GUARD_EN
  localparam logic c_guard_en = 1'b1;
`else
  localparam logic c_guard_en = 1'b0;
`endif

  // One extra bit so that 2*B never wraps, even for the largest B.
  localparam int c_tgl_w = BIT_WIDTH + 1;
  localparam logic [c_tgl_w-1:0]   c_tgl_one = {{(c_tgl_w-1){1'b0}}, 1'b1};
  localparam logic [DIV_WIDTH-1:0] c_div_one = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_RUN   = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [c_tgl_w-1:0]   tgl_q, tgl_d;
  logic [DIV_WIDTH-1:0] half_q, half_d;
  logic [BIT_WIDTH-1:0] bits_q, bits_d;
  logic                 cpol_q, cpol_d;
  logic                 sclk_q, sclk_d;
  logic                 cs_n_q, cs_n_d;
  logic                 lead_q, lead_d;
  logic                 sen_q, sen_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 w_div_hit;
  logic [c_tgl_w-1:0]   w_tgl_next;
  logic [c_tgl_w-1:0]   w_tgl_last;

  assign w_div_hit  = (div_q == half_q);
  assign w_tgl_next = tgl_q + c_tgl_one;
  assign w_tgl_last = {bits_q, 1'b0};

  // Next-state, divider, toggle counter and registered-output computation.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tgl_d   = tgl_q;
    half_d  = half_q;
    bits_d  = bits_q;
    cpol_d  = cpol_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    busy_d  = busy_q;
    lead_d  = 1'b0;
    sen_d   = 1'b0;
    done_d  = 1'b0;

    if (!i_enable) begin
      // Abort: return to idle silently, no done pulse.
      state_d = ST_IDLE;
      div_d   = '0;
      tgl_d   = '0;
      sclk_d  = cpol_q;
      cs_n_d  = 1'b1;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          div_d = '0;
          tgl_d = '0;
          if (i_start && (i_num_bits != '0)) begin
            half_d  = i_half_period;
            bits_d  = i_num_bits;
            cpol_d  = i_cpol;
            sclk_d  = i_cpol;
            cs_n_d  = 1'b0;
            busy_d  = 1'b1;
            state_d = c_guard_en ? ST_SETUP : ST_RUN;
          end
        end

        ST_SETUP: begin
          if (w_div_hit) begin
            div_d   = '0;
            state_d = ST_RUN;
          end else begin
            div_d = div_q + c_div_one;
          end
        end

        ST_RUN: begin
          if (w_div_hit) begin
            div_d  = '0;
            tgl_d  = w_tgl_next;
            sclk_d = ~sclk_q;
            // Odd toggles leave the idle level (leading), even ones return.
            if (w_tgl_next[0]) lead_d = 1'b1;
            else               sen_d  = 1'b1;
            if (w_tgl_next == w_tgl_last) begin
              if (c_guard_en) begin
                state_d = ST_HOLD;
              end else begin
                state_d = ST_IDLE;
                cs_n_d  = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end
            end
          end else begin
            div_d = div_q + c_div_one;
          end
        end

        ST_HOLD: begin
          if (w_div_hit) begin
            div_d   = '0;
            state_d = ST_IDLE;
            cs_n_d  = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            div_d = div_q + c_div_one;
          end
        end

        default: begin
          state_d = ST_IDLE;
          div_d   = '0;
          tgl_d   = '0;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      tgl_q   <= '0;
      half_q  <= '0;
      bits_q  <= '0;
      cpol_q  <= 1'b0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      lead_q  <= 1'b0;
      sen_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tgl_q   <= tgl_d;
      half_q  <= half_d;
      bits_q  <= bits_d;
      cpol_q  <= cpol_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      lead_q  <= lead_d;
      sen_q   <= sen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // While idle (including during reset) SCLK follows the live CPOL input so
  // the idle level is correct immediately; during a transfer it is the
  // registered clock, which started from the CPOL latched at acceptance.
  assign o_sclk        = busy_q ? sclk_q : i_cpol;
  assign o_cs_n        = cs_n_q;
  assign o_lead_edge   = lead_q;
  assign o_sclk_enable = sen_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_sclk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_sclk_gen
//  Description : Self-checking bench for spi_sclk_gen. Transfer vectors with
//                hand-computed edge timing, plus directed corner sequences.
//                Edge numbering: start is driven after edge E0 and sampled
//                by the DUT at E1. Honours SPI_SCLK_GEN_CS_GUARD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_sclk_gen;

  logic       clk;
  logic       rst_n;
  logic       i_enable;
  logic       i_start;
  logic [7:0] i_half_period;
  logic [5:0] i_num_bits;
  logic       i_cpol;
  logic       o_sclk;
  logic       o_cs_n;
  logic       o_lead_edge;
  logic       o_sclk_enable;
  logic       o_busy;
  logic       o_done;

  int total = 0;
  int bad   = 0;

  spi_sclk_gen #(.DIV_WIDTH(8), .BIT_WIDTH(6)) dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_enable      (i_enable),
    .i_start       (i_start),
    .i_half_period (i_half_period),
    .i_num_bits    (i_num_bits),
    .i_cpol        (i_cpol),
    .o_sclk        (o_sclk),
    .o_cs_n        (o_cs_n),
    .o_lead_edge   (o_lead_edge),
    .o_sclk_enable (o_sclk_enable),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int n;          // half-period setting N
    int b;          // bits B
    int cpol;
    int restart;    // edge after whose sample a stray start is driven (0 = none)
    int exp_first;  // edge of first o_lead_edge
    int exp_done;   // edge of o_done
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one transfer and observe it edge by edge.
  task automatic run_xfer(input int n, input int b, input int cpol, input int restart,
                          output int first_lead, output int done_edge,
                          output int leads, output int sens, output int errs);
    logic prev;
    first_lead = -1;
    done_edge  = -1;
    leads = 0;
    sens  = 0;
    errs  = 0;
    prev  = cpol[0];
    @(negedge clk);
    i_half_period = 8'(n);
    i_num_bits    = 6'(b);
    i_cpol        = cpol[0];
    i_start       = 1'b1;
    for (int e = 1; e <= 300; e++) begin
      tick();
      i_start = 1'b0;
      if (e == 1) begin
        // Later input changes must not disturb the transfer.
        i_half_period = 8'(n + 3);
        i_num_bits    = 6'(b + 2);
      end
      if (o_lead_edge) begin
        leads++;
        if (first_lead < 0) first_lead = e;
        if (o_sclk != ~cpol[0]) errs++;
      end else if (o_sclk_enable) begin
        sens++;
        if (o_sclk != cpol[0]) errs++;
      end else if (o_sclk != prev) begin
        errs++;
      end
      prev = o_sclk;
      if (o_done) begin
        done_edge = e;
        if (o_busy || !o_cs_n) errs++;
        break;
      end
      if (!o_busy || o_cs_n) errs++;
      if (e == restart) i_start = 1'b1;
    end
    // Quiet afterwards: no spurious second transfer or done.
    for (int k = 0; k < 4; k++) begin
      tick();
      if (o_busy || o_done || !o_cs_n || o_sclk != cpol[0]) errs++;
    end
  endtask

  initial begin
    int fl, de, nl, ns, er, cnt, seen;

`ifdef SPI_SCLK_GEN_CS_GUARD_EN
    vecs[0] = '{n:1, b:1, cpol:0, restart:2, exp_first:5, exp_done:9};
    vecs[1] = '{n:0, b:8, cpol:1, restart:0, exp_first:3, exp_done:19};
    vecs[2] = '{n:1, b:2, cpol:0, restart:0, exp_first:5, exp_done:13};
    vecs[3] = '{n:2, b:3, cpol:1, restart:0, exp_first:7, exp_done:25};
    vecs[4] = '{n:0, b:1, cpol:0, restart:0, exp_first:3, exp_done:5};
    vecs[5] = '{n:3, b:2, cpol:1, restart:0, exp_first:9, exp_done:25};
`else
    vecs[0] = '{n:1, b:1, cpol:0, restart:2, exp_first:3, exp_done:5};
    vecs[1] = '{n:0, b:8, cpol:1, restart:0, exp_first:2, exp_done:17};
    vecs[2] = '{n:1, b:2, cpol:0, restart:0, exp_first:3, exp_done:9};
    vecs[3] = '{n:2, b:3, cpol:1, restart:0, exp_first:4, exp_done:19};
    vecs[4] = '{n:0, b:1, cpol:0, restart:0, exp_first:2, exp_done:3};
    vecs[5] = '{n:3, b:2, cpol:1, restart:0, exp_first:5, exp_done:17};
`endif

    rst_n = 1'b0;
    i_enable = 1'b1;
    i_start = 1'b0;
    i_half_period = 8'd0;
    i_num_bits = 6'd0;
    i_cpol = 1'b1;

    // Reset values, and SCLK following CPOL while in reset.
    repeat (3) tick();
    check("rst_cs_n", int'(o_cs_n), 1);
    check("rst_busy", int'(o_busy), 0);
    check("rst_strobes", int'({o_lead_edge, o_sclk_enable, o_done}), 0);
    check("rst_sclk_cpol1", int'(o_sclk), 1);
    i_cpol = 1'b0;
    #1;
    check("rst_sclk_cpol0", int'(o_sclk), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Transfer vectors.
    for (int v = 0; v < 6; v++) begin
      run_xfer(vecs[v].n, vecs[v].b, vecs[v].cpol, vecs[v].restart, fl, de, nl, ns, er);
      check($sformatf("v%0d_first_lead", v), fl, vecs[v].exp_first);
      check($sformatf("v%0d_done_edge", v), de, vecs[v].exp_done);
      check($sformatf("v%0d_lead_cnt", v), nl, vecs[v].b);
      check($sformatf("v%0d_sen_cnt", v), ns, vecs[v].b);
      check($sformatf("v%0d_proto_errs", v), er, 0);
    end

    // Start with zero bits is ignored.
    @(negedge clk);
    i_num_bits = 6'd0;
    i_half_period = 8'd1;
    i_start = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      i_start = 1'b0;
      if (o_busy || o_done || !o_cs_n) cnt++;
    end
    check("zero_bits_ignored", cnt, 0);

    // Enable dropped mid-RUN: immediate silent abort.
    @(negedge clk);
    i_half_period = 8'd1;
    i_num_bits = 6'd4;
    i_cpol = 1'b1;
    i_start = 1'b1;
    seen = 0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      tick();
      i_start = 1'b0;
      if (o_lead_edge) seen = 1;
    end
    check("abort_reached_run", seen, 1);
    @(negedge clk);
    i_enable = 1'b0;
    tick();
    check("abort_busy", int'(o_busy), 0);
    check("abort_cs_n", int'(o_cs_n), 1);
    check("abort_sclk", int'(o_sclk), 1);
    check("abort_strobes", int'({o_lead_edge, o_sclk_enable, o_done}), 0);
    // Enable low dominates a start.
    @(negedge clk);
    i_start = 1'b1;
    tick();
    check("disabled_start_busy", int'(o_busy), 0);
    @(negedge clk);
    i_start = 1'b0;
    i_enable = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (o_done || o_busy) cnt++;
    end
    check("abort_no_done", cnt, 0);

    // Back-to-back: start in the done cycle begins the next transfer.
    @(negedge clk);
    i_half_period = 8'd0;
    i_num_bits = 6'd1;
    i_cpol = 1'b0;
    i_start = 1'b1;
    seen = 0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      tick();
      i_start = 1'b0;
      if (o_done) seen = 1;
    end
    check("b2b_first_done", seen, 1);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("b2b_restart_busy", int'(o_busy), 1);
    check("b2b_restart_cs_n", int'(o_cs_n), 0);
    seen = 0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      tick();
      if (o_done) seen = 1;
    end
    check("b2b_second_done", seen, 1);

    // Asynchronous reset mid-transfer.
    repeat (2) tick();
    @(negedge clk);
    i_half_period = 8'd2;
    i_num_bits = 6'd4;
    i_cpol = 1'b0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (5) tick();
    check("pre_rst_busy", int'(o_busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", int'(o_busy), 0);
    check("async_rst_cs_n", int'(o_cs_n), 1);
    check("async_rst_sclk", int'(o_sclk), 0);
    check("async_rst_strobes", int'({o_lead_edge, o_sclk_enable, o_done}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (o_done || o_busy) cnt++;
    end
    check("rst_no_done", cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_sclk_gen.md
SPI_SCLK_GEN -- requirements
Module: spi_sclk_gen

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 8, width of the half-period divider.
REQ-002 SHALL have parameter BIT_WIDTH, default 6, width of the bit-count input.
REQ-003 SHALL have port i_clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port i_reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_enable  input  1  block enable; low aborts any transfer.
REQ-006 SHALL have port i_start  input  1  single-cycle transfer request.
REQ-007 SHALL have port i_half_period  input  DIV_WIDTH  SCLK half-period N; half-period = N+1 i_clk cycles.
REQ-008 SHALL have port i_num_bits  input  BIT_WIDTH  bits per transfer B.
REQ-009 SHALL have port i_cpol  input  1  SCLK idle level.
REQ-010 SHALL have port o_sclk  output  1  serial clock.
REQ-011 SHALL have port o_cs_n  output  1  chip select, active-low.
REQ-012 SHALL have port o_lead_edge  output  1  one-cycle strobe on each SCLK leading edge.
REQ-013 SHALL have port o_sclk_enable  output  1  one-cycle strobe on each SCLK trailing edge (bit boundary), for the downstream bit counter.
REQ-014 SHALL have port o_busy  output  1  high whenever state is not IDLE.
REQ-015 SHALL have port o_done  output  1  one-cycle strobe on normal transfer completion.

Function
REQ-016 SHALL implement states IDLE, SETUP, RUN, HOLD; all outputs registered.
REQ-017 SHALL accept i_start only when state is IDLE, i_enable is 1 and i_num_bits is nonzero; otherwise i_start is ignored with no response.
REQ-018 SHALL latch i_half_period, i_num_bits and i_cpol on acceptance; input changes during a transfer have no effect.
REQ-019 SHALL, on acceptance, enter SETUP at the next edge with o_cs_n=0, o_busy=1 and divider=0.
REQ-020 SHALL, in every non-IDLE state, increment the divider each cycle and, when divider==N, advance the state or toggle as defined below and reload the divider to 0.
REQ-021 SHALL go SETUP->RUN when divider==N.
REQ-022 SHALL, in RUN when divider==N, toggle o_sclk and, in the same cycle as the toggle, pulse o_lead_edge (odd toggles) or o_sclk_enable (even toggles).
REQ-023 SHALL go RUN->HOLD on the edge performing toggle number 2B; o_sclk then equals the latched CPOL.
REQ-024 SHALL go HOLD->IDLE when divider==N, setting o_cs_n=1 and o_busy=0 and pulsing o_done for exactly that one cycle.
REQ-025 SHALL accept i_start in the cycle o_done is high, allowing back-to-back transfers.
REQ-026 SHALL drive o_sclk equal to i_cpol while IDLE and track i_cpol changes in IDLE.
REQ-027 SHALL, when i_enable is 0, go to IDLE at the next edge from any state, with o_cs_n=1, o_sclk=CPOL, all strobes 0 and no o_done pulse; i_enable=0 dominates a simultaneous i_start.
REQ-028 SHALL count toggles in a register at least BIT_WIDTH+1 bits wide so that B at its maximum does not wrap.

Reset
REQ-029 SHALL, while i_reset=0, hold state IDLE, divider 0, toggle count 0, o_sclk=i_cpol, o_cs_n=1, o_lead_edge=0, o_sclk_enable=0, o_busy=0, o_done=0.
REQ-030 SHALL abandon a transfer in progress on reset assertion without emitting o_done.

Configuration
REQ-031 SHALL, with macro SPI_SCLK_GEN_CS_GUARD_EN defined, include the SETUP and HOLD states, each lasting N+1 cycles.
REQ-032 SHALL, without SPI_SCLK_GEN_CS_GUARD_EN, go IDLE->RUN on acceptance and RUN->IDLE, with o_done, on the edge of toggle 2B; o_cs_n is low only during RUN.

Verification
REQ-033 SHALL cover: guard on, N=1, B=2, CPOL=0, start accepted at E0 -> o_cs_n=0 at E1; toggles at E5,E7,E9,E11 (o_sclk 1,0,1,0); o_lead_edge at E5,E9; o_sclk_enable at E7,E11; o_done=1, o_cs_n=1 at E13.
REQ-034 SHALL cover: N=0, B=8, CPOL=1 -> o_sclk toggles every cycle, idles at 1, 8 o_lead_edge and 8 o_sclk_enable pulses, one o_done.
REQ-035 SHALL cover: i_enable dropped mid-RUN -> IDLE next edge, o_cs_n=1, o_sclk=CPOL, no o_done; a second i_start while busy -> ignored.
REQ-036 SHALL cover: i_start with i_num_bits=0 -> o_busy stays 0 and no o_done; i_start in the o_done cycle -> new transfer begins next edge.
REQ-037 SHALL cover: i_reset asserted mid-transfer -> all outputs at reset values asynchronously; guard off, N=1, B=1 -> toggles at E3,E5, o_done at E5.
